bet_latch_bank: RTL and testbench
=================================

BET_LATCH_BANK -- requirements
Module: bet_latch_bank

Interface
REQ-001 Parameter NUM_BETS, default 12, number of bet slots (1..32).
REQ-002 Parameter OPCODE_W, default 6, bet opcode width.
REQ-003 Parameter COLOR_W, default 2, chip-color width; slot width SLOT_W = COLOR_W+OPCODE_W.
REQ-004 Parameter SPIN_OP, default 6'b111110, opcode that starts a spin.
REQ-005 Parameter NULL_OP, default 6'b111111, opcode meaning "no key".
REQ-006 Parameter UNDO_OP, default 6'b111101, undo opcode (used only when BET_UNDO_EN is defined).
REQ-007 clock  input  1  sole clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 key_strobe  input  1  one-cycle pulse per received PS/2 byte.
REQ-010 bet_opcode  input  OPCODE_W  decoded key opcode, valid with key_strobe.
REQ-011 bet_color  input  COLOR_W  chip color from color sensor; 0 = no chip.
REQ-012 spin_done  input  1  one-cycle pulse, payout computation finished.
REQ-013 bets  output  NUM_BETS*SLOT_W  slot k at [k*SLOT_W +: SLOT_W], packed {color, opcode}.
REQ-014 bet_count  output  clog2(NUM_BETS+1)  number of occupied slots.
REQ-015 full  output  1  bet_count == NUM_BETS.
REQ-016 spin_active  output  1  high in SPIN state.
REQ-017 accept  output  1  one-cycle pulse, strobe stored/acted on.
REQ-018 reject  output  1  one-cycle pulse, strobe refused.

Function
REQ-019 FSM states COLLECT, SKIP, SPIN; SKIP discards the PS/2 byte following every handled byte (replaces the divide-by-two counter scheme).
REQ-020 COLLECT + key_strobe with opcode not in {SPIN_OP, NULL_OP}, bet_color != 0, not full: slot[bet_count] <= {bet_color, bet_opcode}, bet_count+1, accept, -> SKIP.
REQ-021 COLLECT + key_strobe with NULL_OP, bet_color == 0, or full: no store, reject, -> SKIP.
REQ-022 COLLECT + key_strobe with SPIN_OP and bet_count > 0: accept, -> SPIN; with bet_count == 0: reject, -> SKIP.
REQ-023 SKIP + key_strobe: no store, no accept/reject, -> COLLECT.
REQ-024 SPIN: key_strobe ignored (no pulses); bets and bet_count frozen.
REQ-025 SPIN + spin_done: all slots zeroed, bet_count <= 0, -> COLLECT, next cycle.
REQ-026 spin_done outside SPIN is ignored.
REQ-027 key_strobe and spin_done in same cycle in SPIN: spin_done wins, strobe dropped.
REQ-028 All outputs registered; store/count/accept/reject visible one cycle after the strobe edge.
REQ-029 accept and reject never high together.

Reset
REQ-030 reset low asynchronously forces: state COLLECT, all slots 0, bet_count 0, full 0, spin_active 0, accept 0, reject 0.
REQ-031 Reset mid-SPIN or mid-SKIP discards all bets; first strobe after release is handled in COLLECT.

Configuration
REQ-032 Macro BET_UNDO_EN defined: COLLECT + key_strobe with UNDO_OP and bet_count > 0 zeroes slot[bet_count-1], decrements bet_count, accept, -> SKIP; with bet_count == 0: reject, -> SKIP; bet_color ignored for undo.
REQ-033 BET_UNDO_EN undefined: UNDO_OP is an ordinary bet opcode per REQ-020/021.

Verification
REQ-034 Reset, then strobes (op 6'h05,col 2),(any),(op 6'h07,col 1),(any) -> bet_count=2, slot0=8'h85, slot1=8'h47, two accepts, no reject.
REQ-035 NUM_BETS=12: 13 valid bets each followed by a skip byte -> bet_count=12, full=1, 13th gives reject, slots unchanged.
REQ-036 Strobe op 6'h05 with col 0, then spin with count 0 -> two rejects, bet_count=0, state returns to COLLECT after each skip byte.
REQ-037 3 bets, spin strobe -> spin_active=1; further strobes change nothing; spin_done -> next cycle bets all 0, bet_count=0, spin_active=0.
REQ-038 Reset low asynchronously (between edges) during SPIN with 5 bets -> all outputs 0 immediately, before next clock edge.
REQ-039 BET_UNDO_EN defined: 2 bets, undo strobe -> bet_count=1, slot1=0, accept; undefined: same undo strobe with col 3 stored as slot2=8'hFD.

Source files
------------

// File: rtl/bet_latch_bank.sv
// bet_latch_bank: latches keyed chip bets into a slot bank and freezes the bank while a spin runs.
// Latency: slot store, bet_count, accept and reject are registered, visible one cycle after the strobe edge.
// Backpressure: none; strobes that cannot be honoured are answered with reject, or dropped during a spin.
// Optional feature: define BET_UNDO_EN to make UNDO_OP remove the most recent bet.
module bet_latch_bank #(
  parameter int                   NUM_BETS = 12,
  parameter int                   OPCODE_W = 6,
  parameter int                   COLOR_W  = 2,
  parameter logic [OPCODE_W-1:0]  SPIN_OP  = 6'b111110,
  parameter logic [OPCODE_W-1:0]  NULL_OP  = 6'b111111,
  parameter logic [OPCODE_W-1:0]  UNDO_OP  = 6'b111101,
  localparam int                  SLOT_W   = COLOR_W + OPCODE_W,
  localparam int                  CNT_W    = $clog2(NUM_BETS + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       key_strobe,
  input  logic [OPCODE_W-1:0]        bet_opcode,
  input  logic [COLOR_W-1:0]         bet_color,
  input  logic                       spin_done,
  output logic [NUM_BETS*SLOT_W-1:0] bets,
  output logic [CNT_W-1:0]           bet_count,
  output logic                       full,
  output logic                       spin_active,
  output logic                       accept,
  output logic                       reject
);

  typedef enum logic [1:0] {COLLECT, SKIP, SPIN} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_BETS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t state;
  logic   bet_ok;

  // An ordinary bet is storable only with a real key, a chip on the sensor and a free slot.
  always_comb begin
    bet_ok = (bet_opcode != NULL_OP) && (bet_color != '0) && !full;
  end

  // Key FSM: every handled byte is followed by one discarded byte (the PS/2 echo/break byte).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      bets        <= '0;
      bet_count   <= '0;
      full        <= 1'b0;
      spin_active <= 1'b0;
      accept      <= 1'b0;
      reject      <= 1'b0;
    end else begin
      accept <= 1'b0;
      reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (key_strobe) begin
            state <= SKIP;
            if (bet_opcode == SPIN_OP) begin
              // A spin needs at least one bet on the table.
              if (bet_count != '0) begin
                accept      <= 1'b1;
                state       <= SPIN;
                spin_active <= 1'b1;
              end else begin
                reject <= 1'b1;
              end
            end
`ifdef BET_UNDO_EN
            else if (bet_opcode == UNDO_OP) begin
              // Undo removes the newest bet; chip color plays no part.
              if (bet_count != '0) begin
                for (int k = 0; k < NUM_BETS; k++) begin
                  if (k == int'(bet_count) - 1) begin
                    bets[k*SLOT_W +: SLOT_W] <= '0;
                  end
                end
                bet_count <= bet_count - ONE;
                full      <= 1'b0;
                accept    <= 1'b1;
              end else begin
                reject <= 1'b1;
              end
            end
`endif
            else if (bet_ok) begin
              for (int k = 0; k < NUM_BETS; k++) begin
                if (k == int'(bet_count)) begin
                  bets[k*SLOT_W +: SLOT_W] <= {bet_color, bet_opcode};
                end
              end
              bet_count <= bet_count + ONE;
              full      <= ((bet_count + ONE) == MAX_CNT);
              accept    <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end
        end

        SKIP: begin
          if (key_strobe) begin
            state <= COLLECT;
          end
        end

        SPIN: begin
          // Bank is frozen; only the payout-finished pulse releases it, and it beats any strobe.
          if (spin_done) begin
            bets        <= '0;
            bet_count   <= '0;
            full        <= 1'b0;
            spin_active <= 1'b0;
            state       <= COLLECT;
          end
        end

        default: begin
          state       <= COLLECT;
          spin_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bet_latch_bank.sv
// tb_bet_latch_bank: scenario tasks drive key strobes, queue the expected response and compare it
// one clock later against a model of the slot bank.
module tb_bet_latch_bank;

  localparam int NB = 12;
  localparam int SW = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          key_strobe = 1'b0;
  logic [5:0]    bet_opcode = '0;
  logic [1:0]    bet_color = '0;
  logic          spin_done = 1'b0;
  logic [NB*SW-1:0] bets;
  logic [CW-1:0] bet_count;
  logic          full;
  logic          spin_active;
  logic          accept;
  logic          reject;

  bet_latch_bank dut (
    .clock      (clock),
    .reset      (reset),
    .key_strobe (key_strobe),
    .bet_opcode (bet_opcode),
    .bet_color  (bet_color),
    .spin_done  (spin_done),
    .bets       (bets),
    .bet_count  (bet_count),
    .full       (full),
    .spin_active(spin_active),
    .accept     (accept),
    .reject     (reject)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] op;
    logic [1:0] col;
    logic       acc;
    logic       rej;
    int         cnt;
  } stim_t;

  stim_t            sb[$];
  logic [NB*SW-1:0] model = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  // One strobe cycle; the expected reaction is queued and the bank model updated.
  task automatic drive_key(input stim_t s);
    @(negedge clock);
    bet_opcode = s.op;
    bet_color  = s.col;
    key_strobe = 1'b1;
    if (s.acc && s.op != 6'h3E) begin
`ifdef BET_UNDO_EN
      if (s.op == 6'h3D) model[s.cnt*SW +: SW] = '0;
      else model[(s.cnt-1)*SW +: SW] = {s.col, s.op};
`else
      model[(s.cnt-1)*SW +: SW] = {s.col, s.op};
`endif
    end
    sb.push_back(s);
    @(negedge clock);
    key_strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_checks++; if (bets !== '0) begin n_fail++; $display("FAIL reset_bets: got %h want 0", bets); end
    n_checks++; if (bet_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bet_count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (spin_active !== 1'b0) begin n_fail++; $display("FAIL reset_spin: got %b want 0", spin_active); end
    n_checks++; if (accept !== 1'b0 || reject !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got acc=%b rej=%b want 0 0", accept, reject); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    stim_t st[$];
    stim_t e;
    do_reset();
    st.push_back('{6'h05, 2'd2, 1'b1, 1'b0, 1});
    st.push_back('{6'h2A, 2'd3, 1'b0, 1'b0, 1});
    st.push_back('{6'h07, 2'd1, 1'b1, 1'b0, 2});
    st.push_back('{6'h11, 2'd1, 1'b0, 1'b0, 2});
    foreach (st[i]) begin
      drive_key(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model) begin
        n_fail++;
        $display("FAIL basic step %0d: got acc=%b rej=%b cnt=%0d bets=%h, want acc=%b rej=%b cnt=%0d bets=%h",
                 i, accept, reject, bet_count, bets, e.acc, e.rej, e.cnt, model);
      end
    end
    n_checks++;
    if (bets[7:0] !== 8'h85 || bets[15:8] !== 8'h47) begin
      n_fail++;
      $display("FAIL basic_slots: got slot0=%h slot1=%h want 85 47", bets[7:0], bets[15:8]);
    end
  endtask

  task automatic test_full();
    stim_t e;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive_key('{6'(k + 1), 2'((k % 3) + 1), (k < 12), (k == 12), (k < 12) ? k + 1 : 12});
      drive_key('{6'h10, 2'd1, 1'b0, 1'b0, (k < 12) ? k + 1 : 12});
      for (int j = 0; j < 2; j++) begin
        e = sb.pop_front();
        n_checks++;
        if (reject !== 1'b0 && j == 1) begin
          n_fail++;
          $display("FAIL full_skip %0d: got rej=%b want 0", k, reject);
        end
      end
      n_checks++;
      if (bet_count !== CW'(e.cnt) || bets !== model || full !== (e.cnt == 12)) begin
        n_fail++;
        $display("FAIL full step %0d: got cnt=%0d full=%b bets=%h, want cnt=%0d full=%b bets=%h",
                 k, bet_count, full, bets, e.cnt, (e.cnt == 12), model);
      end
    end
  endtask

  task automatic test_full_reject();
    stim_t e;
    // Bank is still full from the previous scenario: one more bet must bounce.
    drive_key('{6'h0E, 2'd2, 1'b0, 1'b1, 12});
    e = sb.pop_front();
    n_checks++;
    if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reject: got acc=%b rej=%b cnt=%0d full=%b, want acc=%b rej=%b cnt=%0d full=1",
               accept, reject, bet_count, full, e.acc, e.rej, e.cnt);
    end
    drive_key('{6'h10, 2'd1, 1'b0, 1'b0, 12});
    e = sb.pop_front();
  endtask

  task automatic test_rejects();
    stim_t st[$];
    stim_t e;
    do_reset();
    st.push_back('{6'h05, 2'd0, 1'b0, 1'b1, 0});
    st.push_back('{6'h05, 2'd2, 1'b0, 1'b0, 0});
    st.push_back('{6'h3E, 2'd1, 1'b0, 1'b1, 0});
    st.push_back('{6'h05, 2'd2, 1'b0, 1'b0, 0});
    st.push_back('{6'h3F, 2'd2, 1'b0, 1'b1, 0});
    st.push_back('{6'h05, 2'd2, 1'b0, 1'b0, 0});
    st.push_back('{6'h05, 2'd2, 1'b1, 1'b0, 1});
    foreach (st[i]) begin
      drive_key(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model || spin_active !== 1'b0) begin
        n_fail++;
        $display("FAIL rejects step %0d: got acc=%b rej=%b cnt=%0d spin=%b, want acc=%b rej=%b cnt=%0d spin=0",
                 i, accept, reject, bet_count, spin_active, e.acc, e.rej, e.cnt);
      end
    end
  endtask

  task automatic test_spin();
    stim_t st[$];
    stim_t e;
    do_reset();
    st.push_back('{6'h01, 2'd1, 1'b1, 1'b0, 1});
    st.push_back('{6'h20, 2'd1, 1'b0, 1'b0, 1});
    st.push_back('{6'h02, 2'd2, 1'b1, 1'b0, 2});
    st.push_back('{6'h20, 2'd1, 1'b0, 1'b0, 2});
    st.push_back('{6'h03, 2'd3, 1'b1, 1'b0, 3});
    st.push_back('{6'h20, 2'd1, 1'b0, 1'b0, 3});
    st.push_back('{6'h3E, 2'd1, 1'b1, 1'b0, 3});
    st.push_back('{6'h04, 2'd1, 1'b0, 1'b0, 3});
    st.push_back('{6'h3E, 2'd2, 1'b0, 1'b0, 3});
    st.push_back('{6'h08, 2'd3, 1'b0, 1'b0, 3});
    foreach (st[i]) begin
      drive_key(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model ||
          spin_active !== (i >= 6)) begin
        n_fail++;
        $display("FAIL spin step %0d: got acc=%b rej=%b cnt=%0d spin=%b, want acc=%b rej=%b cnt=%0d spin=%b",
                 i, accept, reject, bet_count, spin_active, e.acc, e.rej, e.cnt, (i >= 6));
      end
    end
    // spin_done together with a strobe: the release wins and the strobe is lost.
    @(negedge clock);
    spin_done  = 1'b1;
    key_strobe = 1'b1;
    bet_opcode = 6'h04;
    bet_color  = 2'd1;
    @(negedge clock);
    spin_done  = 1'b0;
    key_strobe = 1'b0;
    model = '0;
    n_checks++;
    if (bets !== '0 || bet_count !== '0 || spin_active !== 1'b0 || accept !== 1'b0 || reject !== 1'b0) begin
      n_fail++;
      $display("FAIL spin_done: got bets=%h cnt=%0d spin=%b acc=%b rej=%b, want all 0",
               bets, bet_count, spin_active, accept, reject);
    end
    drive_key('{6'h09, 2'd2, 1'b1, 1'b0, 1});
    e = sb.pop_front();
    n_checks++;
    if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model) begin
      n_fail++;
      $display("FAIL spin_after: got acc=%b rej=%b cnt=%0d, want acc=1 rej=0 cnt=1", accept, reject, bet_count);
    end
    // A stray spin_done outside SPIN must leave the bank alone.
    @(negedge clock);
    spin_done = 1'b1;
    @(negedge clock);
    spin_done = 1'b0;
    n_checks++;
    if (bet_count !== CW'(1) || bets !== model || spin_active !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_done: got cnt=%0d spin=%b bets=%h, want cnt=1 spin=0 bets=%h",
               bet_count, spin_active, bets, model);
    end
  endtask

  task automatic test_async_reset();
    stim_t e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_key('{6'(k + 20), 2'd2, 1'b1, 1'b0, k + 1});
      drive_key('{6'h30, 2'd1, 1'b0, 1'b0, k + 1});
    end
    drive_key('{6'h3E, 2'd3, 1'b1, 1'b0, 5});
    while (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (spin_active !== 1'b1 || bet_count !== CW'(5)) begin
      n_fail++;
      $display("FAIL areset_pre: got spin=%b cnt=%0d want spin=1 cnt=5", spin_active, bet_count);
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bets !== '0 || bet_count !== '0 || full !== 1'b0 || spin_active !== 1'b0 || accept !== 1'b0 || reject !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: got bets=%h cnt=%0d full=%b spin=%b acc=%b rej=%b, want all 0",
               bets, bet_count, full, spin_active, accept, reject);
    end
    @(negedge clock);
    reset = 1'b1;
    model = '0;
    drive_key('{6'h05, 2'd2, 1'b1, 1'b0, 1});
    e = sb.pop_front();
    n_checks++;
    if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model) begin
      n_fail++;
      $display("FAIL areset_after_spin: got acc=%b rej=%b cnt=%0d, want acc=1 rej=0 cnt=1", accept, reject, bet_count);
    end
    // Reset while the FSM waits in SKIP: next strobe must be handled, not swallowed.
    do_reset();
    drive_key('{6'h07, 2'd1, 1'b1, 1'b0, 1});
    e = sb.pop_front();
    n_checks++;
    if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model) begin
      n_fail++;
      $display("FAIL areset_after_skip: got acc=%b rej=%b cnt=%0d, want acc=1 rej=0 cnt=1", accept, reject, bet_count);
    end
  endtask

  task automatic test_undo();
    stim_t st[$];
    stim_t e;
    do_reset();
    st.push_back('{6'h05, 2'd2, 1'b1, 1'b0, 1});
    st.push_back('{6'h12, 2'd1, 1'b0, 1'b0, 1});
    st.push_back('{6'h07, 2'd1, 1'b1, 1'b0, 2});
    st.push_back('{6'h12, 2'd1, 1'b0, 1'b0, 2});
`ifdef BET_UNDO_EN
    st.push_back('{6'h3D, 2'd3, 1'b1, 1'b0, 1});
    st.push_back('{6'h12, 2'd1, 1'b0, 1'b0, 1});
    st.push_back('{6'h3D, 2'd0, 1'b1, 1'b0, 0});
    st.push_back('{6'h12, 2'd1, 1'b0, 1'b0, 0});
    st.push_back('{6'h3D, 2'd3, 1'b0, 1'b1, 0});
`else
    st.push_back('{6'h3D, 2'd3, 1'b1, 1'b0, 3});
`endif
    foreach (st[i]) begin
      drive_key(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (accept !== e.acc || reject !== e.rej || bet_count !== CW'(e.cnt) || bets !== model) begin
        n_fail++;
        $display("FAIL undo step %0d: got acc=%b rej=%b cnt=%0d bets=%h, want acc=%b rej=%b cnt=%0d bets=%h",
                 i, accept, reject, bet_count, bets, e.acc, e.rej, e.cnt, model);
      end
    end
`ifdef BET_UNDO_EN
    n_checks++;
    if (bets[15:8] !== 8'h00 || bets[7:0] !== 8'h00) begin
      n_fail++;
      $display("FAIL undo_slots: got slot0=%h slot1=%h want 00 00", bets[7:0], bets[15:8]);
    end
`else
    n_checks++;
    if (bets[23:16] !== 8'hFD || bets[15:8] !== 8'h47) begin
      n_fail++;
      $display("FAIL undo_plain: got slot1=%h slot2=%h want 47 FD", bets[15:8], bets[23:16]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_reject();
    test_rejects();
    test_spin();
    test_async_reset();
    test_undo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
